// File: rtl/imm_decode_if.sv
// imm_decode_if
//   Bundles the fetch-side and execute-side handshake/data signals of the
//   immediate decode stage.
//   master : producer/consumer environment (drives instr, pc_in, in_valid,
//            flush, out_ready; observes everything else)
//   slave  : the decode stage itself
interface imm_decode_if;
  logic [31:0] instr;
  logic [31:0] pc_in;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] imm;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [31:0] pc_out;
  logic        illegal;

  modport master (
    output instr, pc_in, in_valid, flush, out_ready,
    input  in_ready, out_valid, imm, fmt, opcode, rd, rs1, rs2, funct3,
           pc_out, illegal
  );

  modport slave (
    input  instr, pc_in, in_valid, flush, out_ready,
    output in_ready, out_valid, imm, fmt, opcode, rd, rs1, rs2, funct3,
           pc_out, illegal
  );
endinterface

// File: rtl/imm_decode_stage.sv
// imm_decode_stage
//   Registered RV32I decode stage: classifies the instruction format from the
//   opcode, rebuilds and sign-extends the immediate, and holds the result in
//   a one-deep output register with valid/ready handshakes on both sides.
// Ports
//   clk   : clock, rising-edge
//   rst_n : asynchronous active-low reset
//   bus   : imm_decode_if.slave
//           in : instr, pc_in, in_valid, flush, out_ready
//           out: in_ready, out_valid, imm, fmt, opcode, rd, rs1, rs2,
//                funct3, pc_out, illegal
module imm_decode_stage (
  input logic       clk,
  input logic       rst_n,
  imm_decode_if.slave bus
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  logic [31:0] instr;
  logic [2:0]  fmt_d;
  logic [31:0] imm_d;
  logic        in_ready;
  logic        load;

  logic        out_valid_q;
  logic [31:0] imm_q;
  logic [2:0]  fmt_q;
  logic [6:0]  opcode_q;
  logic [4:0]  rd_q;
  logic [4:0]  rs1_q;
  logic [4:0]  rs2_q;
  logic [2:0]  funct3_q;
  logic [31:0] pc_q;
  logic        illegal_q;

  assign instr = bus.instr;

  always_comb begin
    fmt_d = FMT_ILL;
    case (instr[6:0])
      7'b0000011, 7'b0010011, 7'b1100111: fmt_d = FMT_I;
      7'b0100011:                         fmt_d = FMT_S;
      7'b1100011:                         fmt_d = FMT_B;
      7'b0110111, 7'b0010111:             fmt_d = FMT_U;
      7'b1101111:                         fmt_d = FMT_J;
      7'b0110011:                         fmt_d = FMT_R;
      default:                            fmt_d = FMT_ILL;
    endcase
  end

  always_comb begin
    imm_d = 32'd0;
    case (fmt_d)
      FMT_I: imm_d = {{20{instr[31]}}, instr[31:20]};
      FMT_S: imm_d = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B: imm_d = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                      instr[11:8], 1'b0};
      FMT_U: imm_d = {instr[31:12], 12'd0};
      FMT_J: imm_d = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                      instr[30:21], 1'b0};
      default: imm_d = 32'd0;
    endcase
  end

  // Flush blocks acceptance so a redirected beat can never slip in.
  assign in_ready = !bus.flush && (!out_valid_q || bus.out_ready);
  assign load     = bus.in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      imm_q       <= 32'd0;
      fmt_q       <= 3'd0;
      opcode_q    <= 7'd0;
      rd_q        <= 5'd0;
      rs1_q       <= 5'd0;
      rs2_q       <= 5'd0;
      funct3_q    <= 3'd0;
      pc_q        <= 32'd0;
      illegal_q   <= 1'b0;
    end else if (bus.flush) begin
      // data registers intentionally keep stale contents
      out_valid_q <= 1'b0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      imm_q       <= imm_d;
      fmt_q       <= fmt_d;
      opcode_q    <= instr[6:0];
      rd_q        <= instr[11:7];
      rs1_q       <= instr[19:15];
      rs2_q       <= instr[24:20];
      funct3_q    <= instr[14:12];
      pc_q        <= bus.pc_in;
      illegal_q   <= (fmt_d == FMT_ILL);
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.imm       = imm_q;
  assign bus.fmt       = fmt_q;
  assign bus.opcode    = opcode_q;
  assign bus.rd        = rd_q;
  assign bus.rs1       = rs1_q;
  assign bus.rs2       = rs2_q;
  assign bus.funct3    = funct3_q;
  assign bus.pc_out    = pc_q;
  assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_imm_decode_stage.sv
module tb_imm_decode_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  int   lui_acc = 0;

  always #5 clk = ~clk;

  imm_decode_if bus ();

  imm_decode_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode from the ISA field layout, using shifts/masks on the
  // whole word instead of bit concatenation.
  function automatic int ref_fmt(input logic [31:0] i);
    case (i[6:0])
      7'h03, 7'h13, 7'h67: return 1;
      7'h23:               return 2;
      7'h63:               return 3;
      7'h37, 7'h17:        return 4;
      7'h6F:               return 5;
      7'h33:               return 0;
      default:             return 7;
    endcase
  endfunction

  function automatic logic [31:0] ref_imm(input logic [31:0] i);
    logic signed [31:0] s;
    logic [31:0] r;
    s = $signed(i);
    case (ref_fmt(i))
      1: r = $unsigned(s >>> 20);
      2: r = ($unsigned(s >>> 25) << 5) | ((i >> 7) & 32'h1F);
      3: r = ($unsigned(s >>> 31) << 12) | (((i >> 7) & 32'h1) << 11)
           | (((i >> 25) & 32'h3F) << 5) | (((i >> 8) & 32'hF) << 1);
      4: r = i & 32'hFFFF_F000;
      5: r = ($unsigned(s >>> 31) << 20) | (i & 32'h000F_F000)
           | (((i >> 20) & 32'h1) << 11) | (((i >> 21) & 32'h3FF) << 1);
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Model of the held beat
  logic        m_valid = 1'b0;
  logic [31:0] m_instr = 32'd0;
  logic [31:0] m_pc = 32'd0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
    end else if (bus.flush) begin
      m_valid <= 1'b0;
    end else if (bus.in_valid && (!m_valid || bus.out_ready)) begin
      m_valid <= 1'b1;
      m_instr <= bus.instr;
      m_pc    <= bus.pc_in;
    end else if (bus.out_ready) begin
      m_valid <= 1'b0;
    end
  end

  always @(posedge clk)
    if (rst_n && bus.out_valid && bus.out_ready && bus.imm == 32'h1234_5000 && bus.fmt == 3'd4)
      lui_acc++;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
      chk("in_ready", 32'(bus.in_ready), 32'(!bus.flush && (!m_valid || bus.out_ready)));
      if (m_valid) begin
        chk("imm", bus.imm, ref_imm(m_instr));
        chk("fmt", 32'(bus.fmt), 32'(ref_fmt(m_instr)));
        chk("opcode", 32'(bus.opcode), m_instr & 32'h7F);
        chk("rd", 32'(bus.rd), (m_instr >> 7) & 32'h1F);
        chk("rs1", 32'(bus.rs1), (m_instr >> 15) & 32'h1F);
        chk("rs2", 32'(bus.rs2), (m_instr >> 20) & 32'h1F);
        chk("funct3", 32'(bus.funct3), (m_instr >> 12) & 32'h7);
        chk("pc_out", bus.pc_out, m_pc);
        chk("illegal", 32'(bus.illegal), 32'(ref_fmt(m_instr) == 7));
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    bus.in_valid  = v;
    bus.instr     = ins;
    bus.pc_in     = pc;
    bus.out_ready = ordy;
    bus.flush     = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [10];
    logic [31:0] r;
    ops = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h00};
    r = $urandom;
    if ($urandom_range(0, 9) != 0)
      r[6:0] = ops[$urandom_range(0, 9)];
    return r;
  endfunction

  initial begin
    drive(0, 32'd0, 32'd0, 1'b1, 1'b0);

    // model pinned against hand-computed values
    chk("model_lw", ref_imm(32'hFFC1_2283), 32'hFFFF_FFFC);
    chk("model_sw", ref_imm(32'h0060_A423), 32'h0000_0008);
    chk("model_beq", ref_imm(32'hFE00_0CE3), 32'hFFFF_FFF8);
    chk("model_jal", ref_imm(32'h0010_00EF), 32'h0000_0800);
    chk("model_lui", ref_imm(32'h1234_51B7), 32'h1234_5000);

    #1 rst_n = 1'b0;
    #2;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_imm", bus.imm, 32'd0);
    chk("rst_pc_out", bus.pc_out, 32'd0);
    chk("rst_fmt", 32'(bus.fmt), 32'd0);
    chk("rst_illegal", 32'(bus.illegal), 32'd0);
    #9 rst_n = 1'b1;
    #1 chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    tick();

    // lw x5,-4(x2)
    drive(1, 32'hFFC1_2283, 32'h100, 1, 0);
    tick();
    chk("lw_valid", 32'(bus.out_valid), 32'd1);
    chk("lw_imm", bus.imm, 32'hFFFF_FFFC);
    chk("lw_fmt", 32'(bus.fmt), 32'd1);
    chk("lw_rs1", 32'(bus.rs1), 32'd2);
    chk("lw_rd", 32'(bus.rd), 32'd5);
    chk("lw_funct3", 32'(bus.funct3), 32'd2);

    // back-to-back S, B, J
    drive(1, 32'h0060_A423, 32'h104, 1, 0);
    tick();
    chk("sw_imm", bus.imm, 32'h0000_0008);
    chk("sw_fmt", 32'(bus.fmt), 32'd2);
    chk("sw_rs2", 32'(bus.rs2), 32'd6);
    chk("sw_rs1", 32'(bus.rs1), 32'd1);
    chk("sw_pc", bus.pc_out, 32'h104);
    drive(1, 32'hFE00_0CE3, 32'h108, 1, 0);
    tick();
    chk("beq_imm", bus.imm, 32'hFFFF_FFF8);
    chk("beq_fmt", 32'(bus.fmt), 32'd3);
    chk("beq_pc", bus.pc_out, 32'h108);
    drive(1, 32'h0010_00EF, 32'h10C, 1, 0);
    tick();
    chk("jal_imm", bus.imm, 32'h0000_0800);
    chk("jal_fmt", 32'(bus.fmt), 32'd5);
    chk("jal_rd", 32'(bus.rd), 32'd1);
    chk("jal_pc", bus.pc_out, 32'h10C);
    drive(0, 32'd0, 32'd0, 1, 0);
    tick();

    // lui under 3-cycle stall
    lui_acc = 0;
    drive(1, 32'h1234_51B7, 32'h200, 0, 0);
    tick();
    drive(0, 32'd0, 32'd0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      chk("lui_imm_hold", bus.imm, 32'h1234_5000);
      chk("lui_fmt_hold", 32'(bus.fmt), 32'd4);
      chk("lui_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
    end
    drive(0, 32'd0, 32'd0, 1, 0);
    tick();
    tick();
    chk("lui_single_accept", 32'(lui_acc), 32'd1);

    // illegal opcode
    drive(1, 32'h0000_0000, 32'h300, 1, 0);
    tick();
    chk("ill_valid", 32'(bus.out_valid), 32'd1);
    chk("ill_flag", 32'(bus.illegal), 32'd1);
    chk("ill_fmt", 32'(bus.fmt), 32'd7);
    chk("ill_imm", bus.imm, 32'd0);

    // flush over a stalled beat
    drive(1, 32'hFFC1_2283, 32'h400, 0, 0);
    tick();
    drive(1, 32'h1234_51B7, 32'h404, 0, 1);
    #1 chk("flush_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    chk("flush_valid", 32'(bus.out_valid), 32'd0);
    drive(0, 32'd0, 32'd0, 1, 0);
    tick();
    chk("flush_not_captured", 32'(bus.out_valid), 32'd0);

    // asynchronous reset mid-transfer
    drive(1, 32'hFFC1_2283, 32'h500, 0, 0);
    tick();
    chk("arst_pre_valid", 32'(bus.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_imm", bus.imm, 32'd0);
    chk("arst_pc", bus.pc_out, 32'd0);
    chk("arst_rd", 32'(bus.rd), 32'd0);
    chk("arst_fmt", 32'(bus.fmt), 32'd0);
    drive(0, 32'd0, 32'd0, 1, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // randomized traffic checked every cycle by the compare process
    for (int k = 0; k < 3000; k++) begin
      drive(1'($urandom_range(0, 3) != 0), rand_instr(), $urandom,
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
      tick();
    end
    drive(0, 32'd0, 32'd0, 1, 0);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
